// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store memory controller.
//  - l_func      : load funct3 encodings (instr[14:12] of L-type)
//  - s_func      : store funct3 encodings (instr[14:12] of S-type)
//  - lsu_state_t : controller FSM states
//  - lsu_misaligned(): flags illegal funct3 or misaligned address
package lsu_mem_ctrl_pkg;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } l_func;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } s_func;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      RESP,
      DONE
   } lsu_state_t;

   // Returns 1 when the access must be rejected without touching memory:
   // an unknown funct3, or an address not naturally aligned to the access size.
   function automatic logic lsu_misaligned(input logic       we,
                                           input logic [2:0] funct3,
                                           input logic [1:0] addr);
      logic bad;
      bad = 1'b0;
      if (we) begin
         case (funct3)
            SB:      bad = 1'b0;
            SH:      bad = addr[0];
            SW:      bad = |addr;
            default: bad = 1'b1;
         endcase
      end else begin
         case (funct3)
            LB, LBU: bad = 1'b0;
            LH, LHU: bad = addr[0];
            LW:      bad = |addr;
            default: bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bus interfaces of the load/store memory controller.
//  lsu_core_if : core <-> controller request/response and stall.
//                master = core, slave = controller.
//  lsu_dmem_if : controller <-> data memory request/grant/response.
//                master = controller, slave = memory.
interface lsu_core_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [2:0]  rsp_funct3;
   logic [31:0] rsp_daddr;
   logic [31:0] rsp_drdata;
   logic        stall;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_err, rsp_funct3, rsp_daddr, rsp_drdata, stall
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_err, rsp_funct3, rsp_daddr, rsp_drdata, stall
   );
endinterface

interface lsu_dmem_if;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_mem_ctrl_store_align.sv
// Store lane alignment (purely combinational).
//  funct3    in  3   s_func of the store
//  addr_lo   in  2   byte offset within the word
//  wdata     in  32  store data from the core (rv2)
//  be        out 4   byte enables for the addressed lanes
//  lane_data out 32  store data replicated across all lanes
module lsu_store_align
   import lsu_mem_ctrl_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] lane_data
);

   // Data is replicated into every lane so the memory only needs the byte
   // enables to pick the right one; no shifter on the data path.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      be        = 4'b1111;
      lane_data = wdata;
      case (funct3)
         SB: begin
            be        = 4'b0001 << addr_lo;
            lane_data = {4{wdata[7:0]}};
         end
         SH: begin
            be        = 4'b0011 << {addr_lo[1], 1'b0};
            lane_data = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory controller, upstream of L_type.
//  clk, reset : clock and asynchronous active-high reset
//  core       : lsu_core_if.slave  - one request at a time, rsp_* to L_type, stall
//  dmem       : lsu_dmem_if.master - req/gnt address phase, rvalid response phase
// Accepted requests are checked for legal funct3/alignment; legal ones run
// the memory handshake, illegal ones complete with rsp_err and no memory
// access. ADDR+RESP together are bounded by TIMEOUT cycles (TIMEOUT >= 2).
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input logic        clk,
   input logic        reset,
   lsu_core_if.slave  core,
   lsu_dmem_if.master dmem
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   lsu_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q;

   // Request fields registered at accept.
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   // Response registers: hold until the next completion.
   logic        rsp_err_q;
   logic [2:0]  rsp_funct3_q;
   logic [31:0] rsp_daddr_q;
   logic [31:0] rsp_drdata_q;

   logic        rsp_load;
   logic        rsp_err_d;
   logic [2:0]  rsp_funct3_d;
   logic [31:0] rsp_daddr_d;
   logic [31:0] rsp_drdata_d;

   logic        accept;
   logic        illegal;
   logic        timeout;
   logic [3:0]  align_be;
   logic [31:0] align_data;

   assign accept  = core.req_valid && (state_q == IDLE);
   assign illegal = lsu_misaligned(core.req_we, core.req_funct3, core.req_addr[1:0]);
   // Fires in the last allowed ADDR/RESP cycle; it wins over a same-cycle
   // gnt/rvalid so the access never exceeds TIMEOUT cycles.
   assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

   lsu_store_align u_store_align (
      .funct3    (funct3_q),
      .addr_lo   (addr_q[1:0]),
      .wdata     (wdata_q),
      .be        (align_be),
      .lane_data (align_data)
   );

   // Next state and response capture.
   always_comb begin
      state_d      = state_q;
      rsp_load     = 1'b0;
      rsp_err_d    = 1'b1;
      rsp_funct3_d = funct3_q;
      rsp_daddr_d  = addr_q;
      rsp_drdata_d = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (illegal) begin
                  // Fields are not registered yet, so respond straight from the request.
                  state_d      = DONE;
                  rsp_load     = 1'b1;
                  rsp_funct3_d = core.req_funct3;
                  rsp_daddr_d  = core.req_addr;
               end else begin
                  state_d = ADDR;
               end
            end
         end
         ADDR: begin
            if (timeout) begin
               state_d  = DONE;
               rsp_load = 1'b1;
            end else if (dmem.mem_gnt) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (timeout) begin
               state_d  = DONE;
               rsp_load = 1'b1;
            end else if (dmem.mem_rvalid) begin
               state_d      = DONE;
               rsp_load     = 1'b1;
               rsp_err_d    = 1'b0;
               rsp_drdata_d = we_q ? 32'h0 : dmem.mem_rdata;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         funct3_q     <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rsp_err_q    <= 1'b0;
         rsp_funct3_q <= '0;
         rsp_daddr_q  <= '0;
         rsp_drdata_q <= '0;
      end else begin
         // NOTE: registers use non-blocking assignment so every update sees pre-edge values.
         state_q <= state_d;
         if (accept) begin
            cnt_q    <= '0;
            we_q     <= core.req_we;
            funct3_q <= core.req_funct3;
            addr_q   <= core.req_addr;
            wdata_q  <= core.req_wdata;
         end else if (state_q == ADDR || state_q == RESP) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (rsp_load) begin
            rsp_err_q    <= rsp_err_d;
            rsp_funct3_q <= rsp_funct3_d;
            rsp_daddr_q  <= rsp_daddr_d;
            rsp_drdata_q <= rsp_drdata_d;
         end
      end
   end

   assign core.req_ready  = (state_q == IDLE);
   assign core.rsp_valid  = (state_q == DONE);
   assign core.rsp_err    = rsp_err_q;
   assign core.rsp_funct3 = rsp_funct3_q;
   assign core.rsp_daddr  = rsp_daddr_q;
   assign core.rsp_drdata = rsp_drdata_q;
   // Low in DONE so the core retires the access in the rsp_valid cycle.
   assign core.stall      = (state_q == ADDR) || (state_q == RESP) ||
                            ((state_q == IDLE) && core.req_valid);

   // Address-phase outputs come from registered fields, so they are stable
   // for the whole time mem_req is high and forced to 0 otherwise.
   assign dmem.mem_req   = (state_q == ADDR);
   assign dmem.mem_addr  = dmem.mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
   assign dmem.mem_we    = dmem.mem_req && we_q;
   assign dmem.mem_be    = !dmem.mem_req ? 4'b0000 : (we_q ? align_be : 4'b1111);
   assign dmem.mem_wdata = (dmem.mem_req && we_q) ? align_data : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   lsu_core_if core_bus ();
   lsu_dmem_if dmem_bus ();

   lsu_mem_ctrl #(.TIMEOUT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .core  (core_bus),
      .dmem  (dmem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
      core_bus.req_valid  = 1'b1;
      core_bus.req_we     = we;
      core_bus.req_funct3 = f3;
      core_bus.req_addr   = addr;
      core_bus.req_wdata  = wdata;
      tick();
      core_bus.req_valid  = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (core_bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", core_bus.req_ready); end
      checks++; if (core_bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", core_bus.rsp_valid); end
      checks++; if (core_bus.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", core_bus.stall); end
      checks++; if (dmem_bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", dmem_bus.mem_req); end
      checks++; if (dmem_bus.mem_be !== 4'b0000) begin failures++; $display("FAIL rst_mem_be got=%b exp=0000", dmem_bus.mem_be); end
      checks++; if (core_bus.rsp_drdata !== 32'h0) begin failures++; $display("FAIL rst_drdata got=%h exp=0", core_bus.rsp_drdata); end
   endtask

   task automatic test_load_word();
      core_bus.req_valid  = 1'b1;
      core_bus.req_we     = 1'b0;
      core_bus.req_funct3 = 3'b010;
      core_bus.req_addr   = 32'h0010_0004;
      core_bus.req_wdata  = 32'h0;
      #1;
      checks++; if (core_bus.stall !== 1'b1) begin failures++; $display("FAIL lw_stall_idle got=%b exp=1", core_bus.stall); end
      tick();
      core_bus.req_valid = 1'b0;
      // cycle 1: ADDR
      checks++; if (dmem_bus.mem_req !== 1'b1) begin failures++; $display("FAIL lw_mem_req got=%b exp=1", dmem_bus.mem_req); end
      checks++; if (dmem_bus.mem_addr !== 32'h0010_0004) begin failures++; $display("FAIL lw_mem_addr got=%h exp=00100004", dmem_bus.mem_addr); end
      checks++; if (dmem_bus.mem_be !== 4'b1111) begin failures++; $display("FAIL lw_mem_be got=%b exp=1111", dmem_bus.mem_be); end
      checks++; if (dmem_bus.mem_we !== 1'b0) begin failures++; $display("FAIL lw_mem_we got=%b exp=0", dmem_bus.mem_we); end
      checks++; if (core_bus.req_ready !== 1'b0) begin failures++; $display("FAIL lw_ready_busy got=%b exp=0", core_bus.req_ready); end
      dmem_bus.mem_gnt = 1'b1;
      tick();
      dmem_bus.mem_gnt = 1'b0;
      // cycle 2: RESP
      checks++; if (dmem_bus.mem_req !== 1'b0) begin failures++; $display("FAIL lw_req_dropped got=%b exp=0", dmem_bus.mem_req); end
      checks++; if (dmem_bus.mem_addr !== 32'h0) begin failures++; $display("FAIL lw_addr_idle got=%h exp=0", dmem_bus.mem_addr); end
      checks++; if (core_bus.stall !== 1'b1) begin failures++; $display("FAIL lw_stall_resp got=%b exp=1", core_bus.stall); end
      checks++; if (core_bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL lw_early_rsp got=%b exp=0", core_bus.rsp_valid); end
      dmem_bus.mem_rvalid = 1'b1;
      dmem_bus.mem_rdata  = 32'hF1F2_F3F4;
      tick();
      dmem_bus.mem_rvalid = 1'b0;
      dmem_bus.mem_rdata  = 32'h0;
      // cycle 3: DONE
      checks++; if (core_bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL lw_rsp_valid got=%b exp=1", core_bus.rsp_valid); end
      checks++; if (core_bus.rsp_err !== 1'b0) begin failures++; $display("FAIL lw_rsp_err got=%b exp=0", core_bus.rsp_err); end
      checks++; if (core_bus.rsp_drdata !== 32'hF1F2_F3F4) begin failures++; $display("FAIL lw_drdata got=%h exp=f1f2f3f4", core_bus.rsp_drdata); end
      checks++; if (core_bus.rsp_daddr !== 32'h0010_0004) begin failures++; $display("FAIL lw_daddr got=%h exp=00100004", core_bus.rsp_daddr); end
      checks++; if (core_bus.rsp_funct3 !== 3'b010) begin failures++; $display("FAIL lw_funct3 got=%b exp=010", core_bus.rsp_funct3); end
      checks++; if (core_bus.stall !== 1'b0) begin failures++; $display("FAIL lw_stall_done got=%b exp=0", core_bus.stall); end
      tick();
      checks++; if (core_bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL lw_rsp_pulse got=%b exp=0", core_bus.rsp_valid); end
      checks++; if (core_bus.rsp_drdata !== 32'hF1F2_F3F4) begin failures++; $display("FAIL lw_drdata_hold got=%h exp=f1f2f3f4", core_bus.rsp_drdata); end
      checks++; if (core_bus.req_ready !== 1'b1) begin failures++; $display("FAIL lw_ready_back got=%b exp=1", core_bus.req_ready); end
   endtask

   task automatic test_timeout();
      int req_cycles;
      req_cycles = 0;
      issue(1'b0, 3'b010, 32'h0010_0008, 32'h0);
      for (int i = 0; i < 12; i++) begin
         if (dmem_bus.mem_req === 1'b1) req_cycles++;
         if (core_bus.rsp_valid === 1'b1) break;
         tick();
      end
      checks++; if (req_cycles != 8) begin failures++; $display("FAIL to_req_cycles got=%0d exp=8", req_cycles); end
      checks++; if (core_bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL to_rsp_valid got=%b exp=1", core_bus.rsp_valid); end
      checks++; if (core_bus.rsp_err !== 1'b1) begin failures++; $display("FAIL to_rsp_err got=%b exp=1", core_bus.rsp_err); end
      checks++; if (core_bus.rsp_drdata !== 32'h0) begin failures++; $display("FAIL to_drdata got=%h exp=0", core_bus.rsp_drdata); end
      checks++; if (dmem_bus.mem_req !== 1'b0) begin failures++; $display("FAIL to_req_done got=%b exp=0", dmem_bus.mem_req); end
      tick();
      dmem_bus.mem_rvalid = 1'b1;
      dmem_bus.mem_rdata  = 32'h5555_AAAA;
      tick();
      dmem_bus.mem_rvalid = 1'b0;
      checks++; if (core_bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL to_late_rvalid got=%b exp=0", core_bus.rsp_valid); end
      checks++; if (core_bus.req_ready !== 1'b1) begin failures++; $display("FAIL to_late_ready got=%b exp=1", core_bus.req_ready); end
      checks++; if (core_bus.rsp_drdata !== 32'h0) begin failures++; $display("FAIL to_late_drdata got=%h exp=0", core_bus.rsp_drdata); end
   endtask

   task automatic test_store_byte();
      issue(1'b1, 3'b000, 32'h0010_0003, 32'h0000_00A5);
      checks++; if (dmem_bus.mem_be !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", dmem_bus.mem_be); end
      checks++; if (dmem_bus.mem_wdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", dmem_bus.mem_wdata); end
      checks++; if (dmem_bus.mem_we !== 1'b1) begin failures++; $display("FAIL sb_we got=%b exp=1", dmem_bus.mem_we); end
      checks++; if (dmem_bus.mem_addr !== 32'h0010_0000) begin failures++; $display("FAIL sb_addr got=%h exp=00100000", dmem_bus.mem_addr); end
      tick();  // no grant yet: address phase must hold
      checks++; if (dmem_bus.mem_req !== 1'b1 || dmem_bus.mem_be !== 4'b1000 || dmem_bus.mem_wdata !== 32'hA5A5_A5A5)
         begin failures++; $display("FAIL sb_hold got=req%b be%b %h exp=req1 be1000 a5a5a5a5", dmem_bus.mem_req, dmem_bus.mem_be, dmem_bus.mem_wdata); end
      dmem_bus.mem_gnt = 1'b1;
      tick();
      dmem_bus.mem_gnt    = 1'b0;
      dmem_bus.mem_rvalid = 1'b1;
      dmem_bus.mem_rdata  = 32'hDEAD_BEEF;
      tick();
      dmem_bus.mem_rvalid = 1'b0;
      checks++; if (core_bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL sb_rsp_valid got=%b exp=1", core_bus.rsp_valid); end
      checks++; if (core_bus.rsp_drdata !== 32'h0) begin failures++; $display("FAIL sb_drdata got=%h exp=0", core_bus.rsp_drdata); end
      tick();
   endtask

   task automatic test_store_half();
      issue(1'b1, 3'b001, 32'h0010_0002, 32'hFFFF_1234);
      checks++; if (dmem_bus.mem_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", dmem_bus.mem_be); end
      checks++; if (dmem_bus.mem_wdata !== 32'h1234_1234) begin failures++; $display("FAIL sh_wdata got=%h exp=12341234", dmem_bus.mem_wdata); end
      dmem_bus.mem_gnt = 1'b1;
      tick();
      dmem_bus.mem_gnt = 1'b0;
      tick();  // RESP without rvalid
      checks++; if (core_bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL sh_wait got=%b exp=0", core_bus.rsp_valid); end
      dmem_bus.mem_rvalid = 1'b1;
      tick();
      dmem_bus.mem_rvalid = 1'b0;
      checks++; if (core_bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL sh_rsp_valid got=%b exp=1", core_bus.rsp_valid); end
      checks++; if (core_bus.rsp_drdata !== 32'h0) begin failures++; $display("FAIL sh_drdata got=%h exp=0", core_bus.rsp_drdata); end
      checks++; if (core_bus.rsp_daddr !== 32'h0010_0002) begin failures++; $display("FAIL sh_daddr got=%h exp=00100002", core_bus.rsp_daddr); end
      checks++; if (core_bus.rsp_funct3 !== 3'b001) begin failures++; $display("FAIL sh_funct3 got=%b exp=001", core_bus.rsp_funct3); end
      tick();
   endtask

   task automatic test_illegal();
      logic        v_we  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [2:0]  v_f3  [4] = '{3'b001, 3'b010, 3'b011, 3'b011};
      logic [31:0] v_adr [4] = '{32'h0010_0001, 32'h0010_0002, 32'h0010_0000, 32'h0010_0000};
      for (int i = 0; i < 4; i++) begin
         issue(v_we[i], v_f3[i], v_adr[i], 32'hCAFE_F00D);
         checks++; if (dmem_bus.mem_req !== 1'b0) begin failures++; $display("FAIL ill%0d_mem_req got=%b exp=0", i, dmem_bus.mem_req); end
         checks++; if (core_bus.rsp_valid !== 1'b1 || core_bus.rsp_err !== 1'b1)
            begin failures++; $display("FAIL ill%0d_rsp got=v%b e%b exp=v1 e1", i, core_bus.rsp_valid, core_bus.rsp_err); end
         checks++; if (core_bus.rsp_daddr !== v_adr[i]) begin failures++; $display("FAIL ill%0d_daddr got=%h exp=%h", i, core_bus.rsp_daddr, v_adr[i]); end
         tick();
         checks++; if (dmem_bus.mem_req !== 1'b0 || core_bus.req_ready !== 1'b1)
            begin failures++; $display("FAIL ill%0d_after got=req%b rdy%b exp=req0 rdy1", i, dmem_bus.mem_req, core_bus.req_ready); end
      end
      // LBU at byte offset 3 is legal and must reach memory.
      issue(1'b0, 3'b100, 32'h0010_0003, 32'h0);
      checks++; if (dmem_bus.mem_req !== 1'b1) begin failures++; $display("FAIL lbu_mem_req got=%b exp=1", dmem_bus.mem_req); end
      dmem_bus.mem_gnt = 1'b1;
      tick();
      dmem_bus.mem_gnt    = 1'b0;
      dmem_bus.mem_rvalid = 1'b1;
      dmem_bus.mem_rdata  = 32'h1122_3344;
      tick();
      dmem_bus.mem_rvalid = 1'b0;
      checks++; if (core_bus.rsp_err !== 1'b0 || core_bus.rsp_drdata !== 32'h1122_3344)
         begin failures++; $display("FAIL lbu_rsp got=e%b %h exp=e0 11223344", core_bus.rsp_err, core_bus.rsp_drdata); end
      tick();
   endtask

   task automatic test_reset_mid();
      issue(1'b0, 3'b010, 32'h0010_0010, 32'h0);
      dmem_bus.mem_gnt = 1'b1;
      tick();
      dmem_bus.mem_gnt = 1'b0;
      reset = 1'b1;  // now in RESP
      #1;
      checks++; if (core_bus.stall !== 1'b0 || core_bus.req_ready !== 1'b1)
         begin failures++; $display("FAIL mid_state got=stall%b rdy%b exp=stall0 rdy1", core_bus.stall, core_bus.req_ready); end
      checks++; if (core_bus.rsp_drdata !== 32'h0 || core_bus.rsp_err !== 1'b0 || core_bus.rsp_daddr !== 32'h0)
         begin failures++; $display("FAIL mid_rsp got=%h e%b %h exp=0 e0 0", core_bus.rsp_drdata, core_bus.rsp_err, core_bus.rsp_daddr); end
      dmem_bus.mem_rvalid = 1'b1;
      dmem_bus.mem_rdata  = 32'h7777_7777;
      tick();
      reset = 1'b0;
      tick();
      dmem_bus.mem_rvalid = 1'b0;
      checks++; if (core_bus.rsp_valid !== 1'b0 || core_bus.rsp_drdata !== 32'h0)
         begin failures++; $display("FAIL mid_rvalid got=v%b %h exp=v0 0", core_bus.rsp_valid, core_bus.rsp_drdata); end
      tick();
      checks++; if (core_bus.rsp_valid !== 1'b0 || dmem_bus.mem_req !== 1'b0 || core_bus.req_ready !== 1'b1)
         begin failures++; $display("FAIL mid_idle got=v%b req%b rdy%b exp=v0 req0 rdy1", core_bus.rsp_valid, dmem_bus.mem_req, core_bus.req_ready); end
   endtask

   initial begin
      checks              = 0;
      failures            = 0;
      reset               = 1'b1;
      core_bus.req_valid  = 1'b0;
      core_bus.req_we     = 1'b0;
      core_bus.req_funct3 = 3'b000;
      core_bus.req_addr   = 32'h0;
      core_bus.req_wdata  = 32'h0;
      dmem_bus.mem_gnt    = 1'b0;
      dmem_bus.mem_rvalid = 1'b0;
      dmem_bus.mem_rdata  = 32'h0;
      #2;
      test_reset();
      tick();
      reset = 1'b0;
      tick();
      test_load_word();
      test_timeout();
      test_store_byte();
      test_store_half();
      test_illegal();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
